// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and helpers for the PLL sequencer.
package pll_seq_pkg;
  localparam logic [2:0] ST_RESET_PLL  = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] ST_STABLE     = 3'd2;
  localparam logic [2:0] ST_RUN        = 3'd3;
  localparam logic [2:0] ST_PHASE_STEP = 3'd4;
  localparam logic [2:0] ST_PHASE_GAP  = 3'd5;
  localparam logic [2:0] ST_FAIL       = 3'd6;
  typedef enum logic [2:0] {
    S_RESET_PLL  = ST_RESET_PLL,
    S_WAIT_LOCK  = ST_WAIT_LOCK,
    S_STABLE     = ST_STABLE,
    S_RUN        = ST_RUN,
    S_PHASE_STEP = ST_PHASE_STEP,
    S_PHASE_GAP  = ST_PHASE_GAP,
    S_FAIL       = ST_FAIL
  } pll_state_t;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchronizer bringing the PLL lock into the clkin domain.
module pll_lock_sync (
  input  logic clkin,
  input  logic rstn,
  input  logic locked,
  output logic lock_s
);
  logic meta;
  always_ff @(posedge clkin or negedge rstn)
    if (!rstn) {lock_s, meta} <= 2'b00;
    else {lock_s, meta} <= {meta, locked};
endmodule

// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: PLL reset/lock sequencer with retry, failure latch and optional
// dynamic phase stepping (enabled by defining PLL_SEQ_PHASE_CTRL_EN).
module pll_seq_ctrl
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7,
  parameter int STEP_CYCLES   = 4
) (
  input  logic       clkin,
  input  logic       rstn,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rstn,
  input  logic       phase_req,
  input  logic       phase_dir,
  input  logic [1:0] phase_sel,
  output logic       phase_ack,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic [2:0] state,
  output logic [2:0] retries,
  output logic       fail
);
  localparam int CW = $clog2(max2(max2(RST_CYCLES, LOCK_TIMEOUT), max2(STABLE_CYCLES, STEP_CYCLES)) + 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX   = 3'(MAX_RETRIES);
  pll_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retries_q, retries_d;
  logic          lock_s;
  pll_lock_sync u_sync (
    .clkin  (clkin),
    .rstn   (rstn),
    .locked (locked),
    .lock_s (lock_s)
  );
`ifdef PLL_SEQ_PHASE_CTRL_EN
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  logic       phase_start;
  logic       dir_q;
  logic [1:0] sel_q;
  assign phase_start = (state_q == S_RUN) && lock_s && phase_req;
  always_ff @(posedge clkin or negedge rstn)
    if (!rstn) {dir_q, sel_q} <= 3'b000;
    else if (phase_start) {dir_q, sel_q} <= {phase_dir, phase_sel};
  assign phasestep = state_q == S_PHASE_STEP;
  assign phasedir  = dir_q;
  assign phasesel  = sel_q;
  // Ack rides on the last gap cycle so a held request restarts right after RUN resumes.
  assign phase_ack = (state_q == S_PHASE_GAP) && (cnt_q == STEP_LAST) && lock_s;
`else
  logic unused_phase;
  assign unused_phase = ^{phase_req, phase_dir, phase_sel};
  assign phasestep    = 1'b0;
  assign phasedir     = 1'b0;
  assign phasesel     = 2'b00;
  assign phase_ack    = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    retries_d = retries_q;
    case (state_q)
      S_RESET_PLL: if (cnt_q == RST_LAST) begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
      S_WAIT_LOCK: if (lock_s) begin
        state_d = S_STABLE;
        cnt_d   = '0;
      end else if (cnt_q == LOCK_LAST) begin
        cnt_d     = '0;
        state_d   = (retries_q >= RETRY_MAX) ? S_FAIL : S_RESET_PLL;
        retries_d = (retries_q >= RETRY_MAX) ? retries_q : retries_q + 3'd1;
      end
      S_STABLE: if (!lock_s) begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end else if (cnt_q == STABLE_LAST) begin
        state_d   = S_RUN;
        cnt_d     = '0;
        retries_d = '0;
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d   = S_RESET_PLL;
          retries_d = retries_q + 3'd1;
        end
`ifdef PLL_SEQ_PHASE_CTRL_EN
        else if (phase_start) state_d = S_PHASE_STEP;
`endif
      end
`ifdef PLL_SEQ_PHASE_CTRL_EN
      S_PHASE_STEP, S_PHASE_GAP: if (!lock_s) begin
        state_d   = S_RESET_PLL;
        cnt_d     = '0;
        retries_d = retries_q + 3'd1;
      end else if (cnt_q == STEP_LAST) begin
        state_d = (state_q == S_PHASE_STEP) ? S_PHASE_GAP : S_RUN;
        cnt_d   = '0;
      end
`endif
      default: cnt_d = '0;
    endcase
  end
  always_ff @(posedge clkin or negedge rstn)
    if (!rstn) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
    end
  assign pll_rst      = (state_q == S_RESET_PLL) || (state_q == S_FAIL);
  assign sys_rstn     = (state_q == S_RUN) || (state_q == S_PHASE_STEP) || (state_q == S_PHASE_GAP);
  assign fail         = state_q == S_FAIL;
  assign phaseloadreg = 1'b0;
  assign state        = state_q;
  assign retries      = retries_q;
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// tb_pll_seq_ctrl: scoreboard bench; stimulus queues expected state transitions
// (state, retries, cycle, ack count) and a monitor checks each one as it appears.
module tb_pll_seq_ctrl;
  import pll_seq_pkg::*;
  logic clk = 0;
  logic rstn = 1;
  logic locked = 0;
  logic phase_req = 0, phase_dir = 0;
  logic [1:0] phase_sel = 0;
  logic pll_rst, sys_rstn, phase_ack, phasedir, phasestep, phaseloadreg, fail;
  logic [1:0] phasesel;
  logic [2:0] state, retries;
  always #5 clk = ~clk;
  pll_seq_ctrl #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8), .MAX_RETRIES(2), .STEP_CYCLES(4)
  ) dut (
    .clkin(clk), .rstn(rstn), .locked(locked), .pll_rst(pll_rst), .sys_rstn(sys_rstn),
    .phase_req(phase_req), .phase_dir(phase_dir), .phase_sel(phase_sel), .phase_ack(phase_ack),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
    .state(state), .retries(retries), .fail(fail)
  );
  typedef struct {
    logic [2:0] st;
    logic [2:0] ret;
    int at;
    int acks;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int acks = 0;
  int exp_acks = 0;
  int r, c, d, k, m, n;
  logic [2:0] prev;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input logic [2:0] st, input logic [2:0] ret, input int at);
    q.push_back('{st: st, ret: ret, at: at, acks: exp_acks});
  endtask
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic release_rst();
    @(negedge clk);
    rstn = 1;
    r = cyc;
  endtask
  initial begin
    prev = ST_RESET_PLL;
    forever begin
      @(negedge clk);
      if (!rstn) prev = ST_RESET_PLL;
      else begin
        if (phase_ack) acks++;
        if (state != prev) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transition: got state %0d at cycle %0d expected none", state, cyc);
          end else begin
            e = q.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("retries", 32'(retries), 32'(e.ret));
            chk("transition_cycle", 32'(cyc), 32'(e.at));
            chk("ack_count", 32'(acks), 32'(e.acks));
            chk("pll_rst", 32'(pll_rst), 32'(e.st == ST_RESET_PLL || e.st == ST_FAIL));
            chk("sys_rstn", 32'(sys_rstn), 32'(e.st == ST_RUN || e.st == ST_PHASE_STEP || e.st == ST_PHASE_GAP));
            chk("fail_flag", 32'(fail), 32'(e.st == ST_FAIL));
          end
          prev = state;
        end
      end
    end
  end
  initial begin
    #1 rstn = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'(ST_RESET_PLL));
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_sys_rstn", 32'(sys_rstn), 0);
    chk("rst_retries", 32'(retries), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_phase_outs", 32'({phasestep, phase_ack, phasedir, phasesel, phaseloadreg}), 0);
    // Never locks: three attempts, then latched failure.
    release_rst();
    push(ST_WAIT_LOCK, 0, r + 4);
    push(ST_RESET_PLL, 1, r + 104);
    push(ST_WAIT_LOCK, 1, r + 108);
    push(ST_RESET_PLL, 2, r + 208);
    push(ST_WAIT_LOCK, 2, r + 212);
    push(ST_FAIL, 2, r + 312);
    wait_cyc(r + 330);
    chk("fail_hold_state", 32'(state), 32'(ST_FAIL));
    chk("fail_hold_flag", 32'(fail), 1);
    chk("fail_hold_retries", 32'(retries), 2);
    chk("fail_hold_pll_rst", 32'(pll_rst), 1);
    #2 rstn = 0;
    #1;
    chk("async_rst_state", 32'(state), 32'(ST_RESET_PLL));
    chk("async_rst_fail", 32'(fail), 0);
    chk("async_rst_retries", 32'(retries), 0);
    chk("async_rst_pll_rst", 32'(pll_rst), 1);
    // Lock 20 cycles after release.
    release_rst();
    push(ST_WAIT_LOCK, 0, r + 4);
    wait_cyc(r + 20);
    locked = 1;
    push(ST_STABLE, 0, r + 23);
    push(ST_RUN, 0, r + 31);
    // Lock loss in RUN, then relock with a one-cycle glitch at stable count 5.
    c = r + 40;
    wait_cyc(c);
    locked = 0;
    push(ST_RESET_PLL, 1, c + 3);
    push(ST_WAIT_LOCK, 1, c + 7);
    d = c + 10;
    wait_cyc(d);
    locked = 1;
    push(ST_STABLE, 1, d + 3);
    wait_cyc(d + 6);
    locked = 0;
    @(negedge clk);
    locked = 1;
    push(ST_WAIT_LOCK, 1, d + 9);
    push(ST_STABLE, 1, d + 10);
    push(ST_RUN, 0, d + 18);
    k = d + 25;
    wait_cyc(k);
`ifdef PLL_SEQ_PHASE_CTRL_EN
    phase_req = 1; phase_dir = 1; phase_sel = 2;
    push(ST_PHASE_STEP, 0, k + 1);
    push(ST_PHASE_GAP, 0, k + 5);
    exp_acks = 1;
    push(ST_RUN, 0, k + 9);
    for (int i = 0; i < 40 && !phase_ack; i++) @(negedge clk);
    chk("ack1_seen", 32'(phase_ack), 1);
    chk("ack1_cycle", 32'(cyc), 32'(k + 8));
    phase_req = 0;
    chk("phasesel_2", 32'(phasesel), 2);
    chk("phasedir_1", 32'(phasedir), 1);
    // Request held through ack restarts one cycle after RUN resumes.
    m = k + 15;
    wait_cyc(m);
    phase_req = 1; phase_dir = 0; phase_sel = 1;
    push(ST_PHASE_STEP, 0, m + 1);
    push(ST_PHASE_GAP, 0, m + 5);
    exp_acks = 2;
    push(ST_RUN, 0, m + 9);
    push(ST_PHASE_STEP, 0, m + 10);
    push(ST_PHASE_GAP, 0, m + 14);
    exp_acks = 3;
    push(ST_RUN, 0, m + 18);
    wait_cyc(m + 10);
    phase_req = 0;
    chk("phasesel_1", 32'(phasesel), 1);
    chk("phasedir_0", 32'(phasedir), 0);
    // Lock loss mid-step aborts without ack.
    n = m + 25;
    wait_cyc(n);
    phase_req = 1; phase_dir = 1; phase_sel = 3;
    push(ST_PHASE_STEP, 0, n + 1);
    wait_cyc(n + 1);
    locked = 0;
    push(ST_RESET_PLL, 1, n + 4);
    push(ST_WAIT_LOCK, 1, n + 8);
    wait_cyc(n + 2);
    phase_req = 0;
    wait_cyc(n + 5);
    chk("abort_phasestep", 32'(phasestep), 0);
    chk("abort_sys_rstn", 32'(sys_rstn), 0);
    chk("abort_retries", 32'(retries), 1);
    wait_cyc(n + 12);
`else
    phase_req = 1; phase_dir = 1; phase_sel = 2;
    m = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (phasestep || phase_ack) m++;
    end
    chk("no_phase_activity", 32'(m), 0);
    chk("no_phasesel", 32'(phasesel), 0);
    chk("no_phasedir", 32'(phasedir), 0);
    chk("still_run", 32'(state), 32'(ST_RUN));
    phase_req = 0;
`endif
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_seq_ctrl.md
PLL_SEQ_CTRL -- requirements
Module: pll_seq_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_rst held high per attempt.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles to wait for lock before retry.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synced-lock cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 7: failed attempts before FAIL.
REQ-005 SHALL have parameter STEP_CYCLES, default 4: width of phasestep pulse and of the post-pulse gap.
REQ-006 SHALL have ports: clkin  in  1  reference clock, 16 MHz, also clocks this block.
REQ-007 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports: locked  in  1  PLL LOCK, asynchronous to clkin.
REQ-009 SHALL have ports: pll_rst  out  1  drives PLL RST.
REQ-010 SHALL have ports: sys_rstn  out  1  active-low reset for the PLL-clocked logic.
REQ-011 SHALL have ports: phase_req  in  1, phase_dir  in  1, phase_sel  in  2; phase_ack  out  1  single-cycle step-done pulse.
REQ-012 SHALL have ports: phasesel  out  2, phasedir  out  1, phasestep  out  1, phaseloadreg  out  1  to PLL.
REQ-013 SHALL have ports: state  out  3  current state; retries  out  3  attempt count; fail  out  1.

Function
REQ-014 SHALL sync locked through two clkin flops; only the synced value is used.
REQ-015 SHALL implement states RESET_PLL -> WAIT_LOCK -> STABLE -> RUN, plus PHASE_STEP, PHASE_GAP, FAIL.
REQ-016 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-017 WAIT_LOCK: synced lock high -> STABLE; counter reaching LOCK_TIMEOUT -> retries+1 and RESET_PLL, or FAIL if retries==MAX_RETRIES.
REQ-018 STABLE: lock low for any cycle -> restart counter in WAIT_LOCK (no retry increment); STABLE_CYCLES consecutive highs -> RUN.
REQ-019 RUN: sys_rstn=1; retries cleared to 0 on entry.
REQ-020 RUN with synced lock low -> sys_rstn=0 same cycle as state change, retries+1, RESET_PLL.
REQ-021 RUN with phase_req=1 -> latch phase_dir/phase_sel to phasedir/phasesel, enter PHASE_STEP.
REQ-022 PHASE_STEP: phasestep=1 for STEP_CYCLES; then PHASE_GAP: phasestep=0 for STEP_CYCLES; then phase_ack=1 one cycle and RUN.
REQ-023 phase_req outside RUN SHALL be ignored; requester holds it until phase_ack; a request held through phase_ack starts a new step one cycle after return to RUN.
REQ-024 Lock loss during PHASE_STEP/PHASE_GAP SHALL abort the step (no phase_ack), phasestep=0, proceed as REQ-020.
REQ-025 FAIL: pll_rst=1, sys_rstn=0, fail=1; exits only by rstn.
REQ-026 phaseloadreg SHALL be 0 always; all counters saturate-free, width $clog2(param+1).

Reset
REQ-027 On rstn low: state=RESET_PLL, pll_rst=1, sys_rstn=0, retries=0, fail=0, phasestep=0, phasedir=0, phasesel=0, phase_ack=0, sync flops 0.
REQ-028 rstn assertion mid-operation (any state) SHALL return to REQ-027 values immediately; deassertion restarts RESET_PLL count from 0.

Configuration
REQ-029 Macro PLL_SEQ_PHASE_CTRL_EN: defined -> REQ-021..024 present; undefined -> PHASE_STEP/PHASE_GAP absent, phase_req ignored, phase_ack/phasestep/phasedir/phasesel tied 0.

Structure
REQ-030 Shared package pll_seq_pkg SHALL hold the state enum and 3-bit state encoding constants.
REQ-031 Lock synchronizer SHALL be sub-module pll_lock_sync (2-flop, async active-low reset).

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2, STEP_CYCLES=4)
REQ-032 Release rstn, lock high 20 cycles later -> pll_rst high 4 cycles; sys_rstn rises 8 cycles after synced lock (+2 sync latency).
REQ-033 locked never high -> 3 attempts of 4+100 cycles, then fail=1, state=FAIL, retries=2, pll_rst=1.
REQ-034 Lock glitch low 1 cycle at STABLE count 5 -> count restarts, sys_rstn delayed, retries unchanged.
REQ-035 In RUN, phase_req=1 dir=1 sel=2 -> phasestep high 4, low 4, phase_ack 1 cycle, phasesel=2, phasedir=1.
REQ-036 Drop locked during PHASE_STEP -> no phase_ack, sys_rstn=0, retries=1, pll_rst high 4 cycles; macro undefined -> phase_req gives no phasestep activity.
